// File: rtl/sr_ff_pkg.sv
// Shared definitions for the SR flip-flop bank: conflict-resolution modes
// and the single-bit S/R next-state rule.
package sr_ff_pkg;

  localparam int CM_HOLD   = 0;
  localparam int CM_SET    = 1;
  localparam int CM_RESET  = 2;
  localparam int CM_TOGGLE = 3;

  function automatic logic sr_next_state(
    input logic q,
    input logic s,
    input logic r,
    input int   mode
  );
    logic nxt;
    nxt = q;
    case ({s, r})
      2'b10: nxt = 1'b1;
      2'b01: nxt = 1'b0;
      2'b11: begin
        case (mode)
          CM_SET:    nxt = 1'b1;
          CM_RESET:  nxt = 1'b0;
          CM_TOGGLE: nxt = ~q;
          default:   nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One SR channel: enable-gated S/R next-state logic plus the state flop.
// The flop input comes back from the bank so the load mux stays there.
module sr_ff_cell
  import sr_ff_pkg::*;
#(
  parameter int   CONFLICT_MODE = CM_HOLD,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic d,
  output logic sr_next,
  output logic q
);

  logic q_q;

  assign sr_next = en ? sr_next_state(q_q, s, r, CONFLICT_MODE) : q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH clocked SR flip-flops with parallel load, per-bit change
// pulses and a saturating count of S=R=1 conflict cycles.
module sr_ff_bank
  import sr_ff_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               CONFLICT_MODE = CM_HOLD,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter int               CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] changed,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic             conflict_sat
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] changed_q;
  logic [WIDTH-1:0] changed_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sat_q;
  logic             sat_d;
  logic             conflict;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_ff_cell #(
      .CONFLICT_MODE (CONFLICT_MODE),
      .RESET_VALUE   (RESET_VALUE[i])
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .s       (s[i]),
      .r       (r[i]),
      .d       (q_d[i]),
      .sr_next (sr_next[i]),
      .q       (q_q[i])
    );
  end

  assign q_d       = load ? load_val : sr_next;
  assign changed_d = q_d ^ q_q;

  // One count per conflict cycle, however many bits collide.
  assign conflict = en & ~load & (|(s & r));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (conflict && !sat_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    sat_d = (cnt_d == {CNT_W{1'b1}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed_q <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign q            = q_q;
  assign qn           = ~q_q;
  assign changed      = changed_q;
  assign conflict_cnt = cnt_q;
  assign conflict_sat = sat_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: one instance per conflict mode, alternating counter
// widths of 8 and 2, all driven by the same stimulus.
module tb_sr_ff_bank;

  localparam int N = 4;
  localparam logic [7:0] RV = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic load = 1'b0;
  logic clr_cnt = 1'b0;
  logic [7:0] s = '0;
  logic [7:0] r = '0;
  logic [7:0] load_val = '0;

  logic [N-1:0][7:0] q_o;
  logic [N-1:0][7:0] qn_o;
  logic [N-1:0][7:0] ch_o;
  logic [N-1:0][7:0] cnt_o;
  logic [N-1:0]      sat_o;

  int total = 0;
  int bad = 0;

  logic [7:0] m_q  [N];
  logic [7:0] m_ch [N];
  int         m_cnt[N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CW = (g % 2 == 1) ? 2 : 8;
    logic [CW-1:0] cnt_w;
    sr_ff_bank #(
      .WIDTH         (8),
      .CONFLICT_MODE (g),
      .RESET_VALUE   (RV),
      .CNT_W         (CW)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .s            (s),
      .r            (r),
      .load         (load),
      .load_val     (load_val),
      .clr_cnt      (clr_cnt),
      .q            (q_o[g]),
      .qn           (qn_o[g]),
      .changed      (ch_o[g]),
      .conflict_cnt (cnt_w),
      .conflict_sat (sat_o[g])
    );
    assign cnt_o[g] = 8'(cnt_w);
  end

  function automatic int cmax(input int g);
    return (g % 2 == 1) ? 3 : 255;
  endfunction

  task automatic check(input string name, input int g, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d actual=%h required=%h", name, g, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int g = 0; g < N; g++) begin
      check({tag, ".q"}, g, q_o[g], m_q[g]);
      check({tag, ".qn"}, g, qn_o[g], ~m_q[g]);
      check({tag, ".changed"}, g, ch_o[g], m_ch[g]);
      check({tag, ".cnt"}, g, cnt_o[g], 8'(m_cnt[g]));
      check({tag, ".sat"}, g, {7'd0, sat_o[g]}, {7'd0, m_cnt[g] == cmax(g)});
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < N; g++) begin
      m_q[g] = RV;
      m_ch[g] = '0;
      m_cnt[g] = 0;
    end
  endtask

  // Reference: whole-vector mask arithmetic on the current inputs.
  task automatic model_step();
    logic [7:0] nq;
    logic [7:0] both;
    both = s & r;
    for (int g = 0; g < N; g++) begin
      if (load) nq = load_val;
      else if (!en) nq = m_q[g];
      else begin
        nq = (m_q[g] | (s & ~r)) & ~(r & ~s);
        case (g)
          1: nq = nq | both;
          2: nq = nq & ~both;
          3: nq = nq ^ both;
          default: ;
        endcase
      end
      m_ch[g] = nq ^ m_q[g];
      m_q[g] = nq;
      if (clr_cnt) m_cnt[g] = 0;
      else if (en && !load && both != 0 && m_cnt[g] < cmax(g)) m_cnt[g]++;
    end
  endtask

  task automatic cycle(input string tag, input logic e, input logic [7:0] sv, input logic [7:0] rv,
                       input logic ld, input logic [7:0] lv, input logic clr);
    en = e; s = sv; r = rv; load = ld; load_val = lv; clr_cnt = clr;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic              e;
    logic [7:0]        sv;
    logic [7:0]        rv;
    logic              ld;
    logic [7:0]        lv;
    logic              clr;
    logic [N-1:0][7:0] xq;
    logic [N-1:0][7:0] xch;
    int                xcnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [7:0] snap_q [N];
    int         snap_c [N];
    int         exp_seq[5];

    tbl[0] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, {4{8'h00}}, {4{8'hA5}}, 0};
    tbl[1] = '{1'b1, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b0, {4{8'h0F}}, {4{8'h0F}}, 0};
    tbl[2] = '{1'b0, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, {4{8'h0F}}, {4{8'h00}}, 0};
    tbl[3] = '{1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0,
               {8'hF0, 8'h00, 8'hFF, 8'h0F}, {8'hFF, 8'h0F, 8'hF0, 8'h00}, 1};
    tbl[4] = '{1'b1, 8'hFF, 8'h00, 1'b1, 8'h3C, 1'b0,
               {4{8'h3C}}, {8'hCC, 8'h3C, 8'hC3, 8'h33}, 1};
    tbl[5] = '{1'b1, 8'hFF, 8'h00, 1'b1, 8'h3C, 1'b0, {4{8'h3C}}, {4{8'h00}}, 1};
    tbl[6] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, {4{8'h3C}}, {4{8'h00}}, 1};

    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      cycle("tbl", tbl[i].e, tbl[i].sv, tbl[i].rv, tbl[i].ld, tbl[i].lv, tbl[i].clr);
      for (int g = 0; g < N; g++) begin
        check($sformatf("tbl%0d.q", i), g, q_o[g], tbl[i].xq[g]);
        check($sformatf("tbl%0d.changed", i), g, ch_o[g], tbl[i].xch[g]);
        check($sformatf("tbl%0d.cnt", i), g, cnt_o[g], 8'(tbl[i].xcnt));
      end
    end

    // Async reset mid-cycle with q=FF and a nonzero counter.
    cycle("pre_rst_conf", 1'b1, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0);
    cycle("pre_rst_load", 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0);
    async_reset("async_rst");
    for (int g = 0; g < N; g++) begin
      check("rst.q_A5", g, q_o[g], 8'hA5);
      check("rst.qn_5A", g, qn_o[g], 8'h5A);
    end
    cycle("post_rst", 1'b1, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b0);

    // Saturation of the 2-bit counters, then clear during a conflict.
    cycle("sat_clr", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
    exp_seq = '{1, 2, 3, 3, 3};
    for (int k = 0; k < 5; k++) begin
      cycle("sat_run", 1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
      check("sat_seq.cnt", 1, cnt_o[1], 8'(exp_seq[k]));
      check("sat_seq.sat", 1, {7'd0, sat_o[1]}, {7'd0, k >= 2});
      check("wide_seq.cnt", 0, cnt_o[0], 8'(k + 1));
    end
    cycle("clr_conf", 1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b1);
    for (int g = 0; g < N; g++) begin
      check("clr_conf.cnt0", g, cnt_o[g], 8'h00);
      check("clr_conf.sat0", g, {7'd0, sat_o[g]}, 8'h00);
    end

    // Enable gating: nothing moves for four cycles.
    cycle("gate_pre", 1'b1, 8'h33, 8'h11, 1'b0, 8'h00, 1'b0);
    for (int g = 0; g < N; g++) begin
      snap_q[g] = m_q[g];
      snap_c[g] = m_cnt[g];
    end
    for (int k = 0; k < 4; k++) begin
      cycle("gate", 1'b0, 8'($urandom), 8'($urandom), 1'b0, 8'h00, 1'b0);
      for (int g = 0; g < N; g++) begin
        check("gate.q_hold", g, q_o[g], snap_q[g]);
        check("gate.changed0", g, ch_o[g], 8'h00);
        check("gate.cnt_hold", g, cnt_o[g], 8'(snap_c[g]));
      end
    end

    for (int k = 0; k < 400; k++) begin
      cycle("rand", ($urandom % 4) != 0, 8'($urandom), 8'($urandom),
            ($urandom % 8) == 0, 8'($urandom), ($urandom % 16) == 0);
      if (($urandom % 50) == 0) async_reset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_ff_bank.md
# sr_ff_bank

Parametrised, clock-edge-triggered bank of WIDTH set/reset flip-flops. It is the synchronous successor to the single gated SR cell. It adds:
- an asynchronous active-low reset;
- a selectable policy for simultaneous set and reset;
- a parallel load;
- per-bit change pulses;
- a saturating conflict counter.

It sits between control/status logic (sticky flags, mode bits, interrupt-style latches) and any consumer that needs glitch-free Q/Qn.

## Interface
Parameters:
- WIDTH, 8, number of independent SR channels (≥1)
- CONFLICT_MODE, 0, S=R=1 resolution: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle
- RESET_VALUE, '0, WIDTH-bit value of q during and after reset
- CNT_W, 8, width of conflict counter (≥2)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  S/R sample enable
- s  in  WIDTH  per-channel set
- r  in  WIDTH  per-channel reset
- load  in  1  synchronous parallel load, overrides s/r/en
- load_val  in  WIDTH  value written on load
- clr_cnt  in  1  synchronous clear of conflict counter
- q  out  WIDTH  registered state
- qn  out  WIDTH  always exactly ~q
- changed  out  WIDTH  one-cycle pulse per bit that flipped on the last edge
- conflict_cnt  out  CNT_W  saturating count of conflict cycles
- conflict_sat  out  1  high while conflict_cnt is all-ones

## Operation
- Per-bit next state, in priority order:
  - load=1: load_val[i].
  - else en=0: hold.
  - else s=1, r=0: 1.
  - else s=0, r=1: 0.
  - else s=0, r=0: hold.
  - else s=1, r=1: resolved by CONFLICT_MODE (hold / 1 / 0 / ~q[i]).
- qn is derived from the q register, never from a cross-coupled loop. q and qn are never equal, including during reset.
- changed[i] is registered as next_q[i] ^ q[i]. It is high for exactly the cycle after q[i] flips. A load that rewrites the same value gives changed=0.
- Conflict cycle: en=1, load=0, and |(s & r)=1.
  - Each conflict cycle increments conflict_cnt by 1, regardless of how many bits conflict.
  - The counter holds at all-ones; it does not wrap.
- clr_cnt=1 sets conflict_cnt to 0 on the next edge. Clear wins over a same-cycle increment.
- Conflicts are counted in every CONFLICT_MODE, including hold.

## Timing
- Latency: 1 cycle from sampled s/r/load to q, qn and changed.
- conflict_cnt and conflict_sat update on the same edge as q.
- Reset behaviour:
  - rst_n low forces the following immediately, without waiting for clk: q=RESET_VALUE, qn=~RESET_VALUE, changed=0, conflict_cnt=0, conflict_sat=0.
  - Reset asserted mid-operation discards any pending update.
  - The first edge after rst_n rises samples inputs normally.
  - rst_n deassertion is synchronised to clk upstream.
- No combinational path from any input to any output.
- conflict_sat is registered, asserted on the same edge conflict_cnt reaches 2^CNT_W−1, and cleared on the same edge as clr_cnt takes effect.

## Structure
- Package sr_ff_pkg contains:
  - localparams for conflict modes: CM_HOLD=0, CM_SET=1, CM_RESET=2, CM_TOGGLE=3;
  - a function returning next state from (q, s, r, mode).
- Sub-module sr_ff_cell: a single-bit next-state combinational cell plus a flop with async reset to its RESET_VALUE bit.
- sr_ff_bank instantiates WIDTH cells in a generate loop and owns the load mux, the changed register and the conflict counter.

## Test plan
- Reset: RESET_VALUE=8'hA5, rst_n pulsed low mid-cycle with q=8'hFF → q=A5, qn=5A, changed=0, conflict_cnt=0 before the next clk edge.
- Basic set/reset: en=1, s=8'h0F, r=8'hF0 from q=8'h00 → next cycle q=0F, changed=0F; one cycle later changed=00.
- Conflict modes: q=8'h0F, s=r=8'hFF, en=1 for one cycle.

  | CONFLICT_MODE | Required q |
  |---|---|
  | 0 (hold) | 0F |
  | 1 (set-dominant) | FF |
  | 2 (reset-dominant) | 00 |
  | 3 (toggle) | F0 |

  In every mode, conflict_cnt increments by 1.
- Load priority: load=1, load_val=8'h3C, with en=1, s=8'hFF, r=0 → q=3C. Loading 3C again with q=3C → changed=0.
- Counter saturation: CNT_W=2, 5 consecutive conflict cycles → conflict_cnt sequence 1,2,3,3,3; conflict_sat high from the 3rd cycle. clr_cnt asserted during a conflict cycle → conflict_cnt=0, conflict_sat=0.
- Enable gating: en=0 with arbitrary s/r for 4 cycles → q is unchanged, changed=0, conflict_cnt is unchanged.
